// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the RV32M multiply/divide unit.
//   muldiv_op_e    - RV32M funct3 encodings
//   muldiv_state_e - controller states
//   DIV_STEPS      - restoring-division iterations per divide
//   INT_MIN        - most negative 32-bit value (signed-overflow dividend)
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_unit_div_step.sv
// div_step: one combinational restoring-division iteration on unsigned
// magnitudes. The {rem, quot} pair is shifted left by one, the divisor is
// trial-subtracted from the widened remainder, and the new quotient bit is 1
// when the subtraction does not borrow.
//   rem       in  32 : partial remainder
//   quot      in  32 : dividend bits still to shift in / quotient bits so far
//   divisor   in  32 : divisor magnitude
//   rem_next  out 32 : partial remainder after this step
//   quot_next out 32 : quotient/dividend word after this step
module div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quot,
  input  logic [31:0] divisor,
  output logic [31:0] rem_next,
  output logic [31:0] quot_next
);

  logic [32:0] shifted;
  logic [33:0] trial;
  logic        borrow;
  logic        unused_trial_bit;

  assign shifted = {rem, quot[31]};
  assign trial   = {1'b0, shifted} - {2'b00, divisor};
  assign borrow  = trial[33];

  // The remainder stays below the divisor, so a non-borrowing trial always
  // fits in 32 bits and bit 32 carries no information.
  assign unused_trial_bit = trial[32];

  assign rem_next  = borrow ? shifted[31:0] : trial[31:0];
  assign quot_next = {quot[30:0], ~borrow};

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the execute-stage
// ALU. Multiplies take two cycles; divides run a 32-step restoring loop, with
// single-cycle fast paths for divide-by-zero and signed overflow.
//   clk_i     in  1  : clock, rising edge
//   rst_i     in  1  : synchronous active-high reset
//   start_i   in  1  : request, accepted only while ready_o is 1
//   funct3_i  in  3  : RV32M funct3
//   src_a_i   in  32 : rs1 (multiplicand / dividend)
//   src_b_i   in  32 : rs2 (multiplier / divisor)
//   flush_i   in  1  : abort the in-flight operation, no valid_o pulse
//   ready_o   out 1  : idle, can accept
//   busy_o    out 1  : operation in flight (~ready_o)
//   valid_o   out 1  : one-cycle pulse, result_o valid
//   result_o  out 32 : result, held until the next completion
//
// state | meaning
// IDLE  | waiting for start_i; operands latched on accept
// MUL   | 33x33 product formed from latched operands, result captured
// DIV   | one restoring step per cycle, counter runs 31 down to 0
// DONE  | valid_o pulse, result_o already updated on entry
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_reg;
  logic [31:0]   opa;
  logic [31:0]   opb;
  logic [31:0]   rem_acc;
  logic [31:0]   result_reg;
  logic [4:0]    cnt;
  logic          neg_q;
  logic          neg_r;

  // Accept-time decode of the incoming request.
  logic        in_is_div;
  logic        in_signed_div;
  logic        in_is_rem;
  logic        in_div_zero;
  logic        in_div_ovf;
  logic        in_fast;
  logic [31:0] in_fast_res;
  logic [31:0] in_mag_a;
  logic [31:0] in_mag_b;

  assign in_is_div     = funct3_i[2];
  assign in_signed_div = ~funct3_i[0];
  assign in_is_rem     = funct3_i[1];
  assign in_div_zero   = (src_b_i == 32'd0);
  assign in_div_ovf    = in_signed_div && (src_a_i == INT_MIN) && (src_b_i == 32'hFFFF_FFFF);
  assign in_fast       = in_is_div && (in_div_zero || in_div_ovf);
  assign in_mag_a      = (in_signed_div && src_a_i[31]) ? (32'd0 - src_a_i) : src_a_i;
  assign in_mag_b      = (in_signed_div && src_b_i[31]) ? (32'd0 - src_b_i) : src_b_i;

  always_comb begin
    in_fast_res = 32'd0;
    if (in_div_zero) in_fast_res = in_is_rem ? src_a_i : 32'hFFFF_FFFF;
    else             in_fast_res = in_is_rem ? 32'd0 : INT_MIN;
  end

  // Multiply: operands widened to 33 bits with per-op signedness, then
  // sign-extended to 66 bits so the product width is explicit.
  logic               ext_a_sgn;
  logic               ext_b_sgn;
  logic signed [65:0] wide_a;
  logic signed [65:0] wide_b;
  logic        [65:0] prod;
  logic        [31:0] mul_res;
  logic               unused_prod_msbs;

  assign ext_a_sgn = ((op_reg == OP_MULH) || (op_reg == OP_MULHSU)) && opa[31];
  assign ext_b_sgn = (op_reg == OP_MULH) && opb[31];
  assign wide_a    = {{33{ext_a_sgn}}, ext_a_sgn, opa};
  assign wide_b    = {{33{ext_b_sgn}}, ext_b_sgn, opb};
  assign prod      = wide_a * wide_b;
  assign mul_res   = (op_reg == OP_MUL) ? prod[31:0] : prod[63:32];
  assign unused_prod_msbs = ^prod[65:64];

  // Divide: opa shifts out dividend bits and collects quotient bits.
  logic [31:0] step_rem;
  logic [31:0] step_quot;
  logic [31:0] div_res;
  logic        op_is_rem;

  div_step u_div_step (
    .rem       (rem_acc),
    .quot      (opa),
    .divisor   (opb),
    .rem_next  (step_rem),
    .quot_next (step_quot)
  );

  assign op_is_rem = (op_reg == OP_REM) || (op_reg == OP_REMU);

  always_comb begin
    div_res = 32'd0;
    if (op_is_rem) div_res = neg_r ? (32'd0 - step_rem)  : step_rem;
    else           div_res = neg_q ? (32'd0 - step_quot) : step_quot;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (!in_is_div)   state_d = MUL;
            else if (in_fast) state_d = DONE;
            else              state_d = DIV;
          end
        end
        MUL:     state_d = DONE;
        DIV:     if (cnt == 5'd0) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_reg     <= OP_MUL;
      opa        <= 32'd0;
      opb        <= 32'd0;
      rem_acc    <= 32'd0;
      result_reg <= 32'd0;
      cnt        <= 5'd0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (!flush_i) begin
        unique case (state_q)
          IDLE: begin
            if (start_i) begin
              op_reg  <= muldiv_op_e'(funct3_i);
              rem_acc <= 32'd0;
              cnt     <= 5'(DIV_STEPS - 1);
              if (in_is_div) begin
                opa   <= in_mag_a;
                opb   <= in_mag_b;
                neg_q <= in_signed_div && (src_a_i[31] ^ src_b_i[31]);
                neg_r <= in_signed_div && src_a_i[31];
                if (in_fast) result_reg <= in_fast_res;
              end else begin
                opa   <= src_a_i;
                opb   <= src_b_i;
                neg_q <= 1'b0;
                neg_r <= 1'b0;
              end
            end
          end
          MUL: result_reg <= mul_res;
          DIV: begin
            rem_acc <= step_rem;
            opa     <= step_quot;
            cnt     <= cnt - 5'd1;
            if (cnt == 5'd0) result_reg <= div_res;
          end
          default: ;
        endcase
      end
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign busy_o   = ~ready_o;
  assign valid_o  = (state_q == DONE);
  assign result_o = result_reg;

endmodule
